// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Packet-locked round-robin arbiter sharing one UART byte
//             transmitter among N_REQ byte-stream requesters, with watchdog.
//  Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_consume_o,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_consume_i,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o,
    output logic                 timeout_o
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    logic [0:0]       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_gidx;
    logic [WD_W-1:0]  r_wdog;
    logic             r_timeout;

    logic [N_REQ-1:0] w_rot;
    logic [PTR_W:0]   w_off;
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_win;
    logic [PTR_W-1:0] w_next_ptr;
    logic             w_valid;
    logic             w_last;
    logic [7:0]       w_data;
    logic             w_consume;
    logic             w_release;
    logic             w_expire;

    // Rotate requests so bit 0 is the current priority holder, then find the
    // first set bit and map the offset back to an absolute requester index.
    always_comb begin
        w_rot = N_REQ'({req_valid_i, req_valid_i} >> r_ptr);
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = (PTR_W+1)'(i);
        end
        w_sum = {1'b0, r_ptr} + w_off;
        if (w_sum >= (PTR_W+1)'(N_REQ)) w_sum = w_sum - (PTR_W+1)'(N_REQ);
        w_win = w_sum[PTR_W-1:0];
    end

    // Grant is all-zero when idle, so the selected byte and valid fall to 0.
    always_comb begin
        w_valid = 1'b0;
        w_last  = 1'b0;
        w_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_valid = req_valid_i[i];
                w_last  = req_last_i[i];
                w_data  = req_data_i[8*i +: 8];
            end
        end
    end

    assign w_next_ptr = (r_gidx == PTR_W'(N_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);
    assign w_consume  = tx_consume_i & w_valid;
    // Expiry needs valid low, so it can never coincide with a consume.
    assign w_expire   = (r_state == S_LOCK) & ~w_valid & (r_wdog == WD_MAX);
    assign w_release  = (w_consume & w_last) | w_expire;

    assign req_consume_o = r_grant & {N_REQ{w_consume}};
    assign tx_valid_o    = w_valid;
    assign tx_data_o     = w_data;
    assign grant_o       = r_grant;
    assign busy_o        = (r_state == S_LOCK);
    assign timeout_o     = r_timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_ptr     <= '0;
            r_gidx    <= '0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wdog <= '0;
                    if (|req_valid_i) begin
                        r_state <= S_LOCK;
                        r_gidx  <= w_win;
                        r_grant <= N_REQ'(1) << w_win;
                    end
                end
                default: begin
                    if (w_release) begin
                        r_state   <= S_IDLE;
                        r_grant   <= '0;
                        r_ptr     <= w_next_ptr;
                        r_wdog    <= '0;
                        r_timeout <= w_expire;
                    end else if (w_valid) begin
                        r_wdog <= '0;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Testbench for uart_tx_arbiter: requester FIFO model feeding a scoreboard,
// a vector table for the locked data path, and hand sequences for corner cases.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int T = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_consume, grant;
    logic [8*N-1:0] req_data;
    logic           tx_valid, tx_consume, busy, timeout;
    logic [7:0]     tx_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         g;
        logic [7:0] d;
    } exp_t;
    exp_t sb[$];
    logic [8:0] rq[N][$];

    typedef struct {
        logic [3:0] valid;
        logic       cons;
        logic [7:0] d;
        logic       exp_txv;
        logic [3:0] exp_rc;
    } vec_t;
    vec_t vt[8];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(T)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_last_i    (req_last),
        .req_consume_o (req_consume),
        .tx_valid_o    (tx_valid),
        .tx_data_o     (tx_data),
        .tx_consume_i  (tx_consume),
        .grant_o       (grant),
        .busy_o        (busy),
        .timeout_o     (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        tx_consume = 1'b0;
    endtask

    task automatic drive_model();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]        = 1'b1;
                req_last[i]         = rq[i][0][8];
                req_data[8*i +: 8]  = rq[i][0][7:0];
            end else begin
                req_valid[i]        = 1'b0;
                req_last[i]         = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
            end
        end
    endtask

    task automatic push_pkt(input int g, input int n, input logic [7:0] base);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = 8'(base + k);
            rq[g].push_back({(k == n - 1), b});
            sb.push_back('{g, b});
        end
    endtask

    // Drains the scoreboard with the transmitter always ready.
    task automatic run_model(input string name, input int max_cyc, input int exp_idle);
        int         cyc;
        int         idle;
        logic [N-1:0] pops;
        exp_t       e;
        cyc  = 0;
        idle = 0;
        tx_consume = 1'b1;
        while (sb.size() > 0 && cyc < max_cyc) begin
            drive_model();
            #1;
            pops = '0;
            if (!busy) idle++;
            if (tx_valid && tx_consume) begin
                e = sb.pop_front();
                check({name, " data"}, tx_data, e.d);
                check({name, " grant"}, grant, 1 << e.g);
                check({name, " pop"}, req_consume, 1 << e.g);
                pops = req_consume;
            end else begin
                check({name, " nopop"}, req_consume, 0);
            end
            tick();
            for (int i = 0; i < N; i++)
                if (pops[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            cyc++;
        end
        check({name, " drained"}, sb.size(), 0);
        check({name, " idle cycles"}, idle, exp_idle);
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vt[0] = '{4'b0010, 1'b1, 8'h11, 1'b1, 4'b0010};
        vt[1] = '{4'b1111, 1'b1, 8'h12, 1'b1, 4'b0010};
        vt[2] = '{4'b1101, 1'b1, 8'h00, 1'b0, 4'b0000};
        vt[3] = '{4'b1101, 1'b0, 8'h00, 1'b0, 4'b0000};
        vt[4] = '{4'b0010, 1'b0, 8'h77, 1'b1, 4'b0000};
        vt[5] = '{4'b0011, 1'b1, 8'h13, 1'b1, 4'b0010};
        vt[6] = '{4'b0000, 1'b1, 8'h00, 1'b0, 4'b0000};
        vt[7] = '{4'b0010, 1'b1, 8'h14, 1'b1, 4'b0010};

        // Reset values, with consume asserted to show it is ignored
        rst = 1'b1;
        idle_inputs();
        tx_consume = 1'b1;
        tick();
        tick();
        check("rst grant", grant, 0);
        check("rst busy", busy, 0);
        check("rst tx_valid", tx_valid, 0);
        check("rst tx_data", tx_data, 0);
        check("rst timeout", timeout, 0);
        check("rst consume", req_consume, 0);
        rst = 1'b0;
        tx_consume = 1'b0;
        tick();

        // Single requester, 3-byte packet
        push_pkt(0, 3, 8'h41);
        drive_model();
        #1;
        check("t2 grant latency", grant, 0);
        run_model("t2", 20, 1);
        check("t2 busy after", busy, 0);
        check("t2 grant after", grant, 0);

        // ptr is now 1: requester 1 wins over 0
        push_pkt(1, 1, 8'h51);
        push_pkt(0, 1, 8'h50);
        run_model("ptr", 20, 2);

        // Vector table while requester 1 holds the grant
        req_valid = 4'b0010;
        req_data  = 32'hA3A2_10A0;
        tx_consume = 1'b1;
        #1;
        check("idle consume ignored", req_consume, 0);
        check("idle tx_valid", tx_valid, 0);
        tick();
        for (int v = 0; v < 8; v++) begin
            req_valid = vt[v].valid;
            tx_consume = vt[v].cons;
            req_data[15:8] = vt[v].d;
            #1;
            check($sformatf("vec%0d tx_valid", v), tx_valid, vt[v].exp_txv);
            check($sformatf("vec%0d consume", v), req_consume, vt[v].exp_rc);
            check($sformatf("vec%0d grant", v), grant, 4'b0010);
            if (vt[v].exp_txv) check($sformatf("vec%0d data", v), tx_data, vt[v].d);
            tick();
        end
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        req_data[15:8] = 8'h15;
        tx_consume = 1'b1;
        #1;
        check("vec last consume", req_consume, 4'b0010);
        tick();
        check("vec release busy", busy, 0);
        check("vec release timeout", timeout, 0);
        idle_inputs();

        // Watchdog: requester 2 stalls, requester 3 waits with a 1-byte packet
        req_valid = 4'b1100;
        req_last  = 4'b1000;
        req_data  = 32'h3020_0000;
        tx_consume = 1'b1;
        tick();
        check("t4 grant", grant, 4'b0100);
        check("t4 byte1 pop", req_consume, 4'b0100);
        check("t4 byte1 data", tx_data, 8'h20);
        tick();
        req_valid = 4'b1000;
        for (int k = 0; k < T; k++) begin
            #1;
            check($sformatf("t4 hold%0d busy", k), busy, 1);
            check($sformatf("t4 hold%0d pop", k), req_consume, 0);
            check($sformatf("t4 hold%0d timeout", k), timeout, 0);
            tick();
        end
        check("t4 timeout pulse", timeout, 1);
        check("t4 grant released", grant, 0);
        check("t4 busy released", busy, 0);
        tick();
        check("t4 next grant", grant, 4'b1000);
        check("t4 timeout 1cyc", timeout, 0);
        check("t4 req3 pop", req_consume, 4'b1000);
        tick();
        check("t4 req3 released", busy, 0);
        idle_inputs();

        // Valid returns with the last byte exactly on the expiry cycle
        req_valid = 4'b0001;
        req_data  = 32'h0000_0050;
        tx_consume = 1'b1;
        tick();
        check("t5 byte1 pop", req_consume, 4'b0001);
        tick();
        req_valid = 4'b0000;
        for (int k = 0; k < T - 1; k++) begin
            #1;
            check($sformatf("t5 gap%0d busy", k), busy, 1);
            tick();
        end
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        req_data  = 32'h0000_0051;
        #1;
        check("t5 last pop", req_consume, 4'b0001);
        check("t5 last data", tx_data, 8'h51);
        tick();
        check("t5 busy", busy, 0);
        check("t5 no timeout", timeout, 0);
        idle_inputs();
        tick();
        check("t5 no late timeout", timeout, 0);

        // Asynchronous reset in the middle of a packet
        req_valid = 4'b0001;
        req_data  = 32'h0000_0061;
        tx_consume = 1'b1;
        tick();
        #1;
        check("t1 locked pop", req_consume, 4'b0001);
        rst = 1'b1;
        #1;
        check("t1 grant", grant, 0);
        check("t1 busy", busy, 0);
        check("t1 tx_valid", tx_valid, 0);
        check("t1 pop", req_consume, 0);
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Four requesters, 2-byte packets, ptr=0 after reset
        push_pkt(0, 2, 8'h60);
        push_pkt(1, 2, 8'h70);
        push_pkt(2, 2, 8'h80);
        push_pkt(3, 2, 8'h90);
        push_pkt(0, 2, 8'h62);
        run_model("t3", 60, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
